// File: rtl/sysarr_fifo_bank_if.sv
// Handshake/bus bundle for sysarr_fifo_bank.
//   master: drives clear/load/load_vals/shift, observes lane heads and status
//   slave : the FIFO bank itself
// Parameters mirror the bank: NUM_CH lanes, DW bits per word, DEPTH entries.
interface sysarr_fifo_bank_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   clear;
  logic                   load;
  logic [NUM_CH*DW-1:0]   load_vals;
  logic                   shift;
  logic [NUM_CH*DW-1:0]   out_vals;
  logic [NUM_CH-1:0]      out_valid;
  logic                   full;
  logic                   empty_all;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output clear, load, load_vals, shift,
    input  out_vals, out_valid, full, empty_all, count, overflow, underflow
  );

  modport slave (
    input  clear, load, load_vals, shift,
    output out_vals, out_valid, full, empty_all, count, overflow, underflow
  );
endinterface

// File: rtl/sysarr_fifo_bank.sv
// Multi-channel operand FIFO bank feeding one edge of the systolic array.
// One FIFO lane per array row/column; every load writes a full NUM_CH-word
// vector, each lane pops independently so lanes can be skewed for wavefront
// entry. Non-power-of-two DEPTH supported; sticky overflow/underflow flags.
//
// Ports:
//   clk   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - sysarr_fifo_bank_if.slave (clear, load, load_vals, shift in;
//           out_vals, out_valid, full, empty_all, count, overflow, underflow out)
//
// Build option: SYSARR_FIFO_SKEW_EN -- when defined, lane c pops c cycles after
// lane 0 (shift delayed through a NUM_CH-1 stage register). When undefined all
// lanes pop on shift in lockstep.

// Single lane: storage, read pointer, occupancy. Write pointer is shared and
// supplied by the bank so all lanes write the same slot.
module sysarr_fifo_lane #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_ptr,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] cnt
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic          dec;

  assign dec  = pop && (cnt != '0);
  assign head = (cnt != '0) ? mem[rd_ptr] : '0;

  // mem is not touched by clear; stale data is masked by cnt==0.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (dec) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_en, dec})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module sysarr_fifo_bank #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int DW     = 8
) (
  input  logic                clk,
  input  logic                nRST,
  sysarr_fifo_bank_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0][CW-1:0] cnt;
  logic [NUM_CH-1:0][DW-1:0] head;
  logic [NUM_CH-1:0]         pop;
  logic [NUM_CH-1:0]         udf;
  logic [PW-1:0]             wr_ptr;
  logic                      wr_en;
  logic                      full;
  logic                      ovf_q, udf_q;

  // Last lane pops last, so it always holds the most entries.
  assign full  = (cnt[NUM_CH-1] == CW'(DEPTH));
  assign wr_en = bus.load && !full && !bus.clear;

`ifdef SYSARR_FIFO_SKEW_EN
  if (NUM_CH > 1) begin : g_skew
    // vld_pipe[c-1] holds shift delayed c cycles: pop[c] = pop[c-1] one cycle late.
    logic [NUM_CH-2:0] vld_pipe;
    always_ff @(posedge clk or negedge nRST) begin
      if (!nRST)          vld_pipe <= '0;
      else if (bus.clear) vld_pipe <= '0;
      else                vld_pipe <= pop[NUM_CH-2:0];
    end
    assign pop = {vld_pipe, bus.shift};
  end else begin : g_noskew
    assign pop = bus.shift;
  end
`else
  assign pop = {NUM_CH{bus.shift}};
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)          wr_ptr <= '0;
    else if (bus.clear) wr_ptr <= '0;
    else if (wr_en)     wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    sysarr_fifo_lane #(.DEPTH(DEPTH), .DW(DW), .PW(PW), .CW(CW)) u_lane (
      .clk     (clk),
      .nRST    (nRST),
      .clear   (bus.clear),
      .wr_en   (wr_en),
      .wr_ptr  (wr_ptr),
      .wr_data (bus.load_vals[c*DW +: DW]),
      .pop     (pop[c]),
      .head    (head[c]),
      .cnt     (cnt[c])
    );
    assign udf[c]                   = pop[c] && (cnt[c] == '0);
    assign bus.out_valid[c]         = (cnt[c] != '0);
    assign bus.out_vals[c*DW +: DW] = head[c];
  end

  // Sticky error flags; full is taken from registered state, so a same-cycle
  // pop never rescues a load into a full bank.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.load && full) ovf_q <= 1'b1;
      if (|udf)             udf_q <= 1'b1;
    end
  end

  assign bus.full      = full;
  assign bus.empty_all = ~|bus.out_valid;
  assign bus.count     = cnt[NUM_CH-1];
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
endmodule

// File: tb/tb_sysarr_fifo_bank.sv
module tb_sysarr_fifo_bank;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 3;
  localparam int DW     = 8;

  logic clk = 1'b0;
  logic nRST;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sysarr_fifo_bank_if #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH)) bus ();

  sysarr_fifo_bank #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [31:0] v, input logic sh, input logic cl);
    bus.load      = ld;
    bus.load_vals = v;
    bus.shift     = sh;
    bus.clear     = cl;
  endtask

  initial begin
    logic [31:0] vec;
    int p0, p3;
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    nRST = 1'b1;
    step();

    // reset / idle
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_empty", 32'(bus.empty_all), 32'h1);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_vals",  bus.out_vals, 32'h0);
    chk("rst_full",  32'(bus.full), 32'h0);
    chk("rst_ovf",   32'(bus.overflow), 32'h0);
    chk("rst_udf",   32'(bus.underflow), 32'h0);

    // fill
    drive(1'b1, 32'h04030201, 1'b0, 1'b0); step();
    chk("ld1_vals",  bus.out_vals, 32'h04030201);
    chk("ld1_count", 32'(bus.count), 32'h1);
    drive(1'b1, 32'h08070605, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0C0B0A09, 1'b0, 1'b0); step();
    chk("fill_full",  32'(bus.full), 32'h1);
    chk("fill_count", 32'(bus.count), 32'h3);
    chk("fill_vals",  bus.out_vals, 32'h04030201);
    chk("fill_valid", 32'(bus.out_valid), 32'hF);

    // overflow
    drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ovf_flag",  32'(bus.overflow), 32'h1);
    chk("ovf_count", 32'(bus.count), 32'h3);
    chk("ovf_vals",  bus.out_vals, 32'h04030201);

`ifdef SYSARR_FIFO_SKEW_EN
    // wavefront drain: shift high 3 cycles, lane c pops on edges c+1..c+3
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 32'h0, (k <= 3), 1'b0);
      step();
      p0 = (k > 3) ? 3 : k;
      p3 = (k - 3 < 0) ? 0 : ((k - 3 > 3) ? 3 : k - 3);
      chk($sformatf("skew_l0_%0d", k), 32'(bus.out_vals[7:0]),   (p0 < 3) ? 32'(4*p0 + 1) : 32'h0);
      chk($sformatf("skew_l3_%0d", k), 32'(bus.out_vals[31:24]), (p3 < 3) ? 32'(4*p3 + 4) : 32'h0);
      chk($sformatf("skew_full_%0d", k),  32'(bus.full),  (p3 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("skew_count_%0d", k), 32'(bus.count), 32'(3 - p3));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("skew_empty", 32'(bus.empty_all), 32'h1);
    chk("skew_udf",   32'(bus.underflow), 32'h0);
`else
    // lockstep drain
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    chk("dr1_vals",  bus.out_vals, 32'h08070605);
    chk("dr1_count", 32'(bus.count), 32'h2);
    chk("dr1_full",  32'(bus.full), 32'h0);
    step();
    chk("dr2_vals",  bus.out_vals, 32'h0C0B0A09);
    step();
    chk("dr3_vals",  bus.out_vals, 32'h0);
    chk("dr3_empty", 32'(bus.empty_all), 32'h1);
    chk("dr3_udf",   32'(bus.underflow), 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("dr4_udf",   32'(bus.underflow), 32'h1);
    chk("dr4_count", 32'(bus.count), 32'h0);
    chk("dr4_valid", 32'(bus.out_valid), 32'h0);
`endif

    // pointer wrap: 5 load/shift pairs through a 3-deep lane
    for (int k = 0; k < 5; k++) begin
      vec = {8'(k + 8'h40), 8'(k + 8'h30), 8'(k + 8'h20), 8'(k + 8'h10)};
      drive(1'b1, vec, 1'b0, 1'b0); step();
      chk($sformatf("wrap_vals_%0d", k), bus.out_vals, vec);
      drive(1'b0, 32'h0, 1'b1, 1'b0); step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      step(); step(); step();
      chk($sformatf("wrap_empty_%0d", k), 32'(bus.empty_all), 32'h1);
    end
    chk("wrap_ovf_sticky", 32'(bus.overflow), 32'h1);

`ifndef SYSARR_FIFO_SKEW_EN
    // simultaneous load+pop on a non-empty lane keeps count
    drive(1'b1, 32'hA4A3A2A1, 1'b0, 1'b0); step();
    drive(1'b1, 32'hB4B3B2B1, 1'b1, 1'b0); step();
    chk("ldpop_count", 32'(bus.count), 32'h1);
    chk("ldpop_vals",  bus.out_vals, 32'hB4B3B2B1);
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    chk("ldpop_empty", 32'(bus.empty_all), 32'h1);
    // clear flags first so the empty-lane underflow is observable
    drive(1'b0, 32'h0, 1'b0, 1'b1); step();
    chk("clr_udf", 32'(bus.underflow), 32'h0);
    drive(1'b1, 32'hD4D3D2D1, 1'b1, 1'b0); step();
    chk("ldpop_e_udf",   32'(bus.underflow), 32'h1);
    chk("ldpop_e_count", 32'(bus.count), 32'h1);
    chk("ldpop_e_vals",  bus.out_vals, 32'hD4D3D2D1);
    // re-arm overflow for the clear check
    drive(1'b1, 32'h0, 1'b0, 1'b0); step(); step(); step();
    chk("reovf_flag", 32'(bus.overflow), 32'h1);
    drive(1'b0, 32'h0, 1'b1, 1'b0); step(); step(); step();
`endif

    // clear mid-stream with same-cycle load/shift: clear wins
    drive(1'b1, 32'hE4E3E2E1, 1'b0, 1'b0); step();
    chk("pre_clr_valid", 32'(bus.out_valid), 32'hF);
    drive(1'b1, 32'hF4F3F2F1, 1'b1, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("clr_empty", 32'(bus.empty_all), 32'h1);
    chk("clr_count", 32'(bus.count), 32'h0);
    chk("clr_ovf",   32'(bus.overflow), 32'h0);
    chk("clr_udf2",  32'(bus.underflow), 32'h0);
    step(); step(); step();
    chk("clr_stay_empty", 32'(bus.empty_all), 32'h1);
    chk("clr_stay_udf",   32'(bus.underflow), 32'h0);

    // async reset mid-operation
    drive(1'b1, 32'h55667788, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("pre_rst_vals", bus.out_vals, 32'h55667788);
    #2 nRST = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_vals",  bus.out_vals, 32'h0);
    chk("arst_count", 32'(bus.count), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1 nRST = 1'b1;
    step(); step(); step(); step();
    chk("post_rst_udf",   32'(bus.underflow), 32'h0);
    chk("post_rst_empty", 32'(bus.empty_all), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
